// File: rtl/timer_sched_pkg.sv
// Shared definitions for the timer tick scheduler: FSM states, timer register
// map, control word bits and the bus request record used by the sequencer.
package timer_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_PL    = 3'd1,
        ST_WR_PH    = 3'd2,
        ST_WR_CTRL  = 3'd3,
        ST_RUN      = 3'd4,
        ST_CLR_STAT = 3'd5,
        ST_CLR_WAIT = 3'd6,
        ST_STOP     = 3'd7
    } tmr_state_e;

    // Timer register addresses
    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_PERIODL = 3'd2;
    localparam logic [2:0] REG_PERIODH = 3'd3;

    // Control register bit positions
    localparam int unsigned CTRL_ITO   = 32'd0;
    localparam int unsigned CTRL_CONT  = 32'd1;
    localparam int unsigned CTRL_START = 32'd2;
    localparam int unsigned CTRL_STOP  = 32'd3;

    // Control words: continuous run with interrupts, and stop with interrupts off
    localparam logic [15:0] CTRL_WORD_RUN  = (16'd1 << CTRL_START) |
                                             (16'd1 << CTRL_CONT)  |
                                             (16'd1 << CTRL_ITO);
    localparam logic [15:0] CTRL_WORD_STOP = (16'd1 << CTRL_STOP);

    // One bus cycle worth of timer-port signals
    typedef struct packed {
        logic        cs;
        logic        wr_n;
        logic [2:0]  addr;
        logic [15:0] data;
    } bus_req_t;

    localparam bus_req_t BUS_IDLE = '{cs: 1'b0, wr_n: 1'b1, addr: 3'd0, data: 16'd0};

    // Build a single-cycle write request
    function automatic bus_req_t bus_write(input logic [2:0] addr, input logic [15:0] data);
        bus_req_t req;
        req.cs   = 1'b1;
        req.wr_n = 1'b0;
        req.addr = addr;
        req.data = data;
        return req;
    endfunction

    // A zero period would stall the timer, so the smallest usable period is 1
    function automatic logic [31:0] clamp_period(input logic [31:0] period);
        return (period == 32'd0) ? 32'd1 : period;
    endfunction

endpackage

// File: rtl/timer_sched_client_div.sv
// One tick client: counts scheduler ticks and emits a one-cycle pulse every
// (div + 1) ticks while enabled. The >= compare lets a lowered divider take
// effect immediately instead of waiting for the counter to wrap.
module timer_sched_client_div
    import timer_sched_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             tick,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick_pulse
);

    logic [DIV_W-1:0] cnt_r;
    logic             pulse_r;

    assign tick_pulse = pulse_r;

    // Divider counter and pulse register, updated only on scheduler ticks
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_r   <= '0;
            pulse_r <= 1'b0;
        end else begin
            pulse_r <= 1'b0;
            if (tick) begin
                if (!en) begin
                    cnt_r <= '0;
                end else if (cnt_r >= div) begin
                    cnt_r   <= '0;
                    pulse_r <= 1'b1;
                end else begin
                    cnt_r <= cnt_r + DIV_W'(1);
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

endmodule

// File: rtl/timer_tick_scheduler.sv
// Timer tick scheduler: programs an external interval timer over a simple
// register bus, services its level interrupt, counts timeouts and fans each
// timeout out to N_CLIENTS divided tick outputs.
module timer_tick_scheduler
    import timer_sched_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int DIV_W     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_start,
    input  logic                       cfg_stop,
    input  logic [31:0]                cfg_period,
    input  logic [N_CLIENTS-1:0]       client_en,
    input  logic [N_CLIENTS*DIV_W-1:0] client_div,
    output logic [2:0]                 tmr_address,
    output logic                       tmr_chipselect,
    output logic                       tmr_write_n,
    output logic [15:0]                tmr_writedata,
    input  logic                       tmr_irq,
    output logic [N_CLIENTS-1:0]       tick_pulse,
    output logic [31:0]                tick_count,
    output logic                       busy,
    output logic                       running
);

    tmr_state_e  state_r;
    bus_req_t    bus_r;
    logic [15:0] period_hi_r;
    logic [31:0] tick_count_r;
    logic        stop_pending_r;
    logic        busy_r;
    logic        running_r;

    logic        start_accept_s;
    logic        tick_event_s;
    logic [31:0] period_clamped_s;

    assign start_accept_s   = (state_r == ST_IDLE) && cfg_start;
    assign tick_event_s     = (state_r == ST_RUN) && tmr_irq;
    assign period_clamped_s = clamp_period(cfg_period);

    assign tmr_address    = bus_r.addr;
    assign tmr_chipselect = bus_r.cs;
    assign tmr_write_n    = bus_r.wr_n;
    assign tmr_writedata  = bus_r.data;
    assign tick_count     = tick_count_r;
    assign busy           = busy_r;
    assign running        = running_r;

    // Sequencer: programs the timer, services interrupts, handles stop requests
    // and drives every bus/status output from the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            bus_r          <= BUS_IDLE;
            period_hi_r    <= 16'd0;
            tick_count_r   <= 32'd0;
            stop_pending_r <= 1'b0;
            busy_r         <= 1'b0;
            running_r      <= 1'b0;
        end else begin
            bus_r <= BUS_IDLE;
            case (state_r)
                ST_IDLE: begin
                    if (cfg_start) begin
                        period_hi_r    <= period_clamped_s[31:16];
                        tick_count_r   <= 32'd0;
                        stop_pending_r <= 1'b0;
                        busy_r         <= 1'b1;
                        running_r      <= 1'b0;
                        bus_r          <= bus_write(REG_PERIODL, period_clamped_s[15:0]);
                        state_r        <= ST_WR_PL;
                    end else begin
                        busy_r    <= 1'b0;
                        running_r <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                ST_WR_PL: begin
                    if (cfg_stop) stop_pending_r <= 1'b1;
                    bus_r   <= bus_write(REG_PERIODH, period_hi_r);
                    state_r <= ST_WR_PH;
                end
                ST_WR_PH: begin
                    if (cfg_stop) stop_pending_r <= 1'b1;
                    bus_r   <= bus_write(REG_CONTROL, CTRL_WORD_RUN);
                    state_r <= ST_WR_CTRL;
                end
                ST_WR_CTRL: begin
                    if (cfg_stop) stop_pending_r <= 1'b1;
                    running_r <= 1'b1;
                    state_r   <= ST_RUN;
                end
                ST_RUN: begin
                    if (tmr_irq) begin
                        // Interrupt wins over a simultaneous stop; the stop is kept pending
                        if (cfg_stop) stop_pending_r <= 1'b1;
                        tick_count_r <= tick_count_r + 32'd1;
                        bus_r        <= bus_write(REG_STATUS, 16'h0000);
                        state_r      <= ST_CLR_STAT;
                    end else if (cfg_stop || stop_pending_r) begin
                        stop_pending_r <= 1'b0;
                        running_r      <= 1'b0;
                        bus_r          <= bus_write(REG_CONTROL, CTRL_WORD_STOP);
                        state_r        <= ST_STOP;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_CLR_STAT: begin
                    if (cfg_stop) stop_pending_r <= 1'b1;
                    state_r <= ST_CLR_WAIT;
                end
                ST_CLR_WAIT: begin
                    // The timer still shows irq here; it drops one cycle after the clear
                    if (cfg_stop) stop_pending_r <= 1'b1;
                    state_r <= ST_RUN;
                end
                ST_STOP: begin
                    busy_r    <= 1'b0;
                    running_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    busy_r         <= 1'b0;
                    running_r      <= 1'b0;
                    stop_pending_r <= 1'b0;
                    state_r        <= ST_IDLE;
                end
            endcase
        end
    end

    // One divider per client, all advanced by the same tick event
    for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_client
        timer_sched_client_div #(
            .DIV_W(DIV_W)
        ) u_div (
            .clk        (clk),
            .reset      (reset),
            .clear      (start_accept_s),
            .tick       (tick_event_s),
            .en         (client_en[gi]),
            .div        (client_div[gi*DIV_W +: DIV_W]),
            .tick_pulse (tick_pulse[gi])
        );
    end

endmodule

// File: doc/timer_tick_scheduler.md
TIMER_TICK_SCHEDULER -- requirements
Module: timer_tick_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: port clk (rising edge) and port reset (active-high, sampled only on the rising edge of clk).
REQ-002 N_CLIENTS, default 4: number of tick clients.
REQ-003 DIV_W, default 8: width of each client divider.
REQ-004 clk  in  1  system clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 cfg_start  in  1  one-cycle pulse: program the timer and start ticking.
REQ-007 cfg_stop  in  1  one-cycle pulse: stop the timer.
REQ-008 cfg_period  in  32  timer period in clk cycles minus 1; sampled on an accepted cfg_start.
REQ-009 client_en  in  N_CLIENTS  per-client enable.
REQ-010 client_div  in  N_CLIENTS*DIV_W  per-client divider; client i uses bits [i*DIV_W +: DIV_W].
REQ-011 tmr_address  out  3  timer register address.
REQ-012 tmr_chipselect  out  1  timer select.
REQ-013 tmr_write_n  out  1  active-low write strobe.
REQ-014 tmr_writedata  out  16  timer write data.
REQ-015 tmr_irq  in  1  timer interrupt, level.
REQ-016 tick_pulse  out  N_CLIENTS  one-cycle per-client tick.
REQ-017 tick_count  out  32  serviced timeouts since the last accepted start.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 running  out  1  high in RUN, CLR_STAT and CLR_WAIT.

Function
REQ-020 All outputs SHALL be registered. Each bus write SHALL last exactly one cycle, with tmr_chipselect=1 and tmr_write_n=0. When no write is in progress, the bus SHALL be idle: chipselect=0, write_n=1, address=0, writedata=0.
REQ-021 FSM states SHALL be IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_STAT, CLR_WAIT and STOP. Each state except IDLE and RUN SHALL last one cycle.
REQ-022 IDLE: on cfg_start, the block SHALL latch cfg_period (a value of 0 is clamped to 1), clear tick_count and all client counters, and go to WR_PL.
REQ-023 WR_PL SHALL write address 2 with period[15:0]. WR_PH SHALL write address 3 with period[31:16]. WR_CTRL SHALL write address 1 with 0x0007 (START, CONT, ITO). The next state after WR_CTRL SHALL be RUN.
REQ-024 RUN with tmr_irq=1 SHALL be a tick event: tick_count increments (wrapping 0xFFFFFFFF to 0), then the FSM goes to CLR_STAT.
REQ-025 CLR_STAT SHALL write address 0 with 0x0000. CLR_WAIT SHALL ignore tmr_irq, because the timer drops irq one cycle after the status write. The FSM SHALL then return to RUN.
REQ-026 RUN with tmr_irq=0 and cfg_stop (or stop_pending) SHALL go to STOP. STOP SHALL write address 1 with 0x0008 (STOP, ITO=0), then go to IDLE.
REQ-027 cfg_stop arriving in WR_PL..WR_CTRL, CLR_STAT or CLR_WAIT SHALL set stop_pending, which is honoured in the next RUN cycle. If tmr_irq and stop coincide in RUN, the irq SHALL be serviced first.
REQ-028 cfg_start SHALL be ignored outside IDLE. cfg_stop SHALL be ignored in IDLE and STOP.
REQ-029 Per client, on each tick event: if client_en[i]=0, cnt SHALL be set to 0. Otherwise, if cnt >= div[i], tick_pulse[i] SHALL be asserted and cnt SHALL be set to 0; else cnt SHALL increment.
REQ-030 tick_pulse SHALL be high for exactly the cycle the FSM is in CLR_STAT. div=0 SHALL mean a pulse on every tick.
REQ-031 A client_div change SHALL take effect at the next tick. The >= compare SHALL prevent lockout when cnt exceeds a reduced div.
REQ-032 tmr_irq in IDLE, WR_* and STOP SHALL be ignored and SHALL NOT count.

Reset
REQ-033 Reset SHALL put the FSM in IDLE, idle the bus, and clear tick_pulse, tick_count, busy, running, stop_pending and all client counters.
REQ-034 Reset in any state SHALL abort the current write, and the bus SHALL be idle after that edge. The timer is not reset by this block: it SHALL be reprogrammed by the next cfg_start.

Structure
REQ-035 The shared package timer_sched_pkg SHALL hold:
- the state enum;
- register address constants STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3;
- control bit constants ITO=0, CONT=1, START=2, STOP=3.
REQ-036 Sub-module timer_sched_client_div (one counter, compare and pulse) SHALL be instantiated N_CLIENTS times.

Verification
REQ-037 Reset, then cfg_start with cfg_period=0x0001869F -> writes (2,0x869F), (3,0x0001), (1,0x0007) on three consecutive cycles; running=1 in the following cycle.
REQ-038 In RUN, hold tmr_irq high 2 cycles -> one write (0,0x0000), tick_count=1, tick_pulse on enabled div=0 clients high 1 cycle.
REQ-039 Set client_div=2 for client 1 and issue 7 ticks -> tick_pulse[1] on ticks 3 and 6 only. Disabling client 1 mid-count -> no pulse, and counting restarts from 0 when re-enabled.
REQ-040 cfg_stop during WR_PH -> WR_CTRL completes, one RUN cycle, then write (1,0x0008), then IDLE with busy=0.
REQ-041 tmr_irq and cfg_stop in the same RUN cycle -> CLR_STAT, CLR_WAIT, STOP in order; tick_count increments once.
REQ-042 Reset asserted in WR_PH -> bus idle after that edge. tick_count preset to 0xFFFFFFFF then ticked -> wraps to 0.
